led_pattern_gen: RTL and testbench

//  Parametrised LED activity driver for the SoC top level: internal prescaler tick plus

---
 rtl/led_pattern_gen_pkg.sv | 24 ++
 rtl/led_pattern_gen_prescaler.sv | 38 +++
 rtl/led_pattern_gen.sv | 155 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_gen_pkg.sv
// Package: led_pkg
// Shared types for the LED pattern generator.
//   led_mode_e : runtime pattern mode selected by mode_i
//   scan_dir_e : travel direction of the bouncing scan and the breathe ramp
package led_pkg;

  typedef enum logic [1:0] {
    LED_COUNT   = 2'd0,
    LED_SCAN    = 2'd1,
    LED_BREATHE = 2'd2,
    LED_MANUAL  = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } scan_dir_e;

  // Prescaler counter width; DIV is always >= 2 so the result is >= 1.
  function automatic int unsigned prescale_w(input int unsigned div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// Module: led_prescaler
// Step-rate prescaler for the LED pattern engine.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   en_i   in  1 = count, 0 = hold (tick_o forced low)
//   clr_i  in  restart the count from 0 (only acts while en_i=1)
//   tick_o out one-cycle strobe while the counter sits at DIV-1
module led_prescaler
  import led_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = prescale_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign tick_o    = en_i && w_at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en_i) begin
      if (clr_i || w_at_last) r_cnt <= '0;
      else                    r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Module: led_pattern_gen
// Registered N-bit LED pattern engine with a prescaled step strobe.
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   en_i       in  1 = run, 0 = freeze prescaler, pattern state, PWM and leds
//   mode_i     in  0 COUNT, 1 SCAN, 2 BREATHE, 3 MANUAL
//   pattern_i  in  LED value used in MANUAL mode
//   tick_o     out one-cycle step strobe
//   leds       out registered LED drive, active-high
// Build option: define LED_BREATHE_EN to build the BREATHE duty/PWM logic;
// without it mode 2 runs the COUNT pattern with identical timing.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 5,
  parameter int unsigned PRESCALE_DIV = 2**21,
  parameter int unsigned PWM_W        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  input  logic [NUM_LEDS-1:0] pattern_i,
  output logic                tick_o,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int unsigned POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  led_mode_e           r_mode_q;
  led_mode_e           w_mode_in;
  logic                w_restart;
  logic                w_step;
  logic [NUM_LEDS-1:0] r_count;
  logic [POS_W-1:0]    r_pos,  w_pos_nxt;
  scan_dir_e           r_dir,  w_dir_nxt;
  logic [NUM_LEDS-1:0] w_scan_leds;
  logic [NUM_LEDS-1:0] w_leds_nxt;

  assign w_mode_in = led_mode_e'(mode_i);
  // A mode change restarts every engine and swallows a coincident tick.
  assign w_restart = en_i && (w_mode_in != r_mode_q);
  assign w_step    = tick_o && !w_restart;

  led_prescaler #(.DIV(PRESCALE_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .clr_i  (w_restart),
    .tick_o (tick_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)    r_mode_q <= LED_COUNT;
    else if (en_i) r_mode_q <= w_mode_in;
  end

  // Binary counter, wraps naturally at 2**NUM_LEDS.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_count <= '0;
    else if (w_restart) r_count <= '0;
    else if (w_step)    r_count <= r_count + NUM_LEDS'(1);
  end

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_pos <= w_pos_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  // Scan FSM: next state. Direction flips on arrival at an end so each end
  // is lit for a single step.
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (w_restart) begin
      w_pos_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (w_step && (NUM_LEDS > 1)) begin
      unique case (r_dir)
        DIR_UP: begin
          w_pos_nxt = r_pos + POS_W'(1);
          if (r_pos + POS_W'(1) == POS_LAST) w_dir_nxt = DIR_DOWN;
        end
        DIR_DOWN: begin
          w_pos_nxt = r_pos - POS_W'(1);
          if (r_pos == POS_W'(1)) w_dir_nxt = DIR_UP;
        end
        default: ;
      endcase
    end
  end

  // Scan FSM: output
  always_comb begin
    w_scan_leds = NUM_LEDS'(1) << r_pos;
  end

`ifdef LED_BREATHE_EN
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_duty;
  scan_dir_e        r_duty_dir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt  <= '0;
      r_duty     <= '0;
      r_duty_dir <= DIR_UP;
    end else if (en_i) begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      if (w_restart) begin
        r_duty     <= '0;
        r_duty_dir <= DIR_UP;
      end else if (w_step) begin
        if (r_duty_dir == DIR_UP) begin
          r_duty <= r_duty + PWM_W'(1);
          if (r_duty + PWM_W'(1) == DUTY_MAX) r_duty_dir <= DIR_DOWN;
        end else begin
          r_duty <= r_duty - PWM_W'(1);
          if (r_duty == PWM_W'(1)) r_duty_dir <= DIR_UP;
        end
      end
    end
  end
`endif

  always_comb begin
    w_leds_nxt = r_count;
    unique case (r_mode_q)
      LED_COUNT:   w_leds_nxt = r_count;
      LED_SCAN:    w_leds_nxt = w_scan_leds;
`ifdef LED_BREATHE_EN
      LED_BREATHE: w_leds_nxt = {NUM_LEDS{r_pwm_cnt < r_duty}};
`else
      LED_BREATHE: w_leds_nxt = r_count;
`endif
      LED_MANUAL:  w_leds_nxt = pattern_i;
      default:     w_leds_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    leds <= '0;
    else if (en_i) leds <= w_leds_nxt;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen: 5-LED and 1-LED instances share stimulus and
// are compared every cycle against a step-count based reference model.
module tb_led_pattern_gen;

  localparam int N   = 5;
  localparam int DIV = 4;
  localparam int W   = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] pat = '0;
  logic         tick, tick1;
  logic [N-1:0] leds;
  logic [0:0]   leds1;

  int n_pass = 0;
  int n_total = 0;

  // reference model state: prescaler phase, steps since restart, PWM phase
  int           m_pre = 0, m_steps = 0, m_mode_q = 0, m_pwm = 0;
  logic [N-1:0] m_leds = '0;
  logic [0:0]   m_leds1 = '0;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LEDS(N), .PRESCALE_DIV(DIV), .PWM_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode),
    .pattern_i(pat), .tick_o(tick), .leds(leds));

  led_pattern_gen #(.NUM_LEDS(1), .PRESCALE_DIV(DIV), .PWM_W(W)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode),
    .pattern_i(pat[0:0]), .tick_o(tick1), .leds(leds1));

  function automatic int scan_pos(input int k, input int n);
    int period, p;
    if (n == 1) return 0;
    period = 2 * (n - 1);
    p = k % period;
    return (p < n) ? p : period - p;
  endfunction

  function automatic int duty_of(input int k);
    int mx, p;
    mx = (1 << W) - 1;
    p = k % (2 * mx);
    return (p <= mx) ? p : 2 * mx - p;
  endfunction

  function automatic logic [31:0] led_value(input int md, input int k, input int pwm,
                                            input logic [31:0] p, input int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    case (md)
      1: return 32'd1 << scan_pos(k, n);
`ifdef LED_BREATHE_EN
      2: return (pwm < duty_of(k)) ? mask : 32'd0;
`endif
      3: return p & mask;
      default: return 32'(k % (1 << n));
    endcase
  endfunction

  function automatic logic exp_tick();
    return en && (m_pre == DIV - 1);
  endfunction

  // Advance one clock; inputs must already be driven (called at negedge).
  task automatic clk_cycle();
    int n_pre, n_steps, n_mq, n_pwm;
    logic [N-1:0] n_leds;
    logic [0:0]   n_leds1;
    n_pre = m_pre; n_steps = m_steps; n_mq = m_mode_q; n_pwm = m_pwm;
    n_leds = m_leds; n_leds1 = m_leds1;
    if (!rst_n) begin
      n_pre = 0; n_steps = 0; n_mq = 0; n_pwm = 0; n_leds = '0; n_leds1 = '0;
    end else if (en) begin
      n_leds  = N'(led_value(m_mode_q, m_steps, m_pwm, 32'(pat), N));
      n_leds1 = 1'(led_value(m_mode_q, m_steps, m_pwm, 32'(pat), 1));
      if (int'(mode) != m_mode_q) begin
        n_pre = 0; n_steps = 0;
      end else if (m_pre == DIV - 1) begin
        n_pre = 0; n_steps = m_steps + 1;
      end else begin
        n_pre = m_pre + 1;
      end
      n_mq  = int'(mode);
      n_pwm = (m_pwm + 1) % (1 << W);
    end
    @(posedge clk);
    m_pre = n_pre; m_steps = n_steps; m_mode_q = n_mq; m_pwm = n_pwm;
    m_leds = n_leds; m_leds1 = n_leds1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_cycle();
    clk_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    en = 1'b0; mode = 2'd0;
    do_reset();
    n_total++;
    if (leds !== '0 || tick !== 1'b0 || leds1 !== 1'b0)
      $display("FAIL reset_state leds=%h tick=%b leds1=%b required 00/0/0", leds, tick, leds1);
    else n_pass++;
    en = 1'b1;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      if (tick === 1'b1) first = i;
      clk_cycle();
    end
    n_total++;
    if (first != DIV) $display("FAIL reset_first_tick cycle=%0d required %0d", first, DIV);
    else n_pass++;
    mode = 2'd1;
    for (int i = 0; i < 14; i++) clk_cycle();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      n_total++;
      if (leds !== '0 || tick !== 1'b0 || leds !== m_leds)
        $display("FAIL reset_mid_scan leds=%h tick=%b required 00/0", leds, tick);
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    logic [N-1:0] seen[$];
    logic [N-1:0] prev;
    int last_tick, bad_cyc, bad_per;
    mode = 2'd0; en = 1'b1;
    do_reset();
    prev = leds; last_tick = -1; bad_cyc = 0; bad_per = 0;
    for (int c = 0; c < 170 && seen.size() < 40; c++) begin
      if (tick === 1'b1) begin
        if (last_tick >= 0 && c - last_tick != DIV) bad_per++;
        last_tick = c;
      end
      clk_cycle();
      if (tick !== exp_tick() || leds !== m_leds || leds1 !== m_leds1) bad_cyc++;
      if (leds !== prev) begin seen.push_back(leds); prev = leds; end
    end
    n_total++;
    if (bad_cyc != 0) $display("FAIL count_model mismatching_cycles=%0d required 0", bad_cyc);
    else n_pass++;
    n_total++;
    if (bad_per != 0) $display("FAIL count_tick_period bad_periods=%0d required 0", bad_per);
    else n_pass++;
    n_total++;
    if (seen.size() != 40) $display("FAIL count_len got=%0d required 40", seen.size());
    else n_pass++;
    for (int i = 0; i < seen.size(); i++) begin
      n_total++;
      if (seen[i] !== N'((i + 1) % 32))
        $display("FAIL count_seq[%0d] got=%h required %h", i, seen[i], N'((i + 1) % 32));
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    logic [N-1:0] exp_seq [10] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10,
                                   5'h08, 5'h04, 5'h02, 5'h01, 5'h02};
    logic [N-1:0] seen[$];
    logic [N-1:0] prev;
    int bad_cyc, bad1;
    en = 1'b1; mode = 2'd0;
    do_reset();
    mode = 2'd1;
    prev = leds; bad_cyc = 0; bad1 = 0;
    for (int c = 0; c < 60 && seen.size() < 10; c++) begin
      clk_cycle();
      if (tick !== exp_tick() || leds !== m_leds || leds1 !== m_leds1) bad_cyc++;
      if (c >= 1 && leds1 !== 1'b1) bad1++;
      if (leds !== prev) begin seen.push_back(leds); prev = leds; end
    end
    n_total++;
    if (bad_cyc != 0) $display("FAIL scan_model mismatching_cycles=%0d required 0", bad_cyc);
    else n_pass++;
    n_total++;
    if (bad1 != 0) $display("FAIL scan_single_led bad_cycles=%0d required 0", bad1);
    else n_pass++;
    n_total++;
    if (seen.size() != 10) $display("FAIL scan_len got=%0d required 10", seen.size());
    else n_pass++;
    for (int i = 0; i < seen.size(); i++) begin
      n_total++;
      if (seen[i] !== exp_seq[i])
        $display("FAIL scan_seq[%0d] got=%h required %h", i, seen[i], exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_breathe();
    int bad_cyc, bad_dark;
    logic [N-1:0] seen[$];
    logic [N-1:0] prev;
    en = 1'b1; mode = 2'd0;
    do_reset();
    mode = 2'd2;
    bad_cyc = 0; bad_dark = 0; prev = leds;
    for (int c = 0; c < 30 * DIV + 8; c++) begin
      clk_cycle();
      if (tick !== exp_tick() || leds !== m_leds || leds1 !== m_leds1) bad_cyc++;
`ifdef LED_BREATHE_EN
      if (c < 5 && leds !== '0) bad_dark++;
`else
      if (leds !== prev) begin seen.push_back(leds); prev = leds; end
`endif
    end
    n_total++;
    if (bad_cyc != 0) $display("FAIL breathe_model mismatching_cycles=%0d required 0", bad_cyc);
    else n_pass++;
`ifdef LED_BREATHE_EN
    n_total++;
    if (bad_dark != 0) $display("FAIL breathe_duty0_dark lit_cycles=%0d required 0", bad_dark);
    else n_pass++;
`else
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (seen.size() <= i || seen[i] !== N'(i + 1))
        $display("FAIL breathe_as_count[%0d] got=%h required %h", i,
                 (seen.size() > i) ? seen[i] : 'x, N'(i + 1));
      else n_pass++;
    end
`endif
  endtask

  task automatic test_mode_switch();
    bit found;
    en = 1'b1; mode = 2'd0;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      clk_cycle();
      if (tick === 1'b1) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL switch_tick_wait tick=%b required 1 within 10 cycles", tick);
    else n_pass++;
    mode = 2'd1;
    for (int j = 1; j <= 6; j++) begin
      clk_cycle();
      n_total++;
      if (leds !== m_leds || tick !== exp_tick() ||
          (j >= 2 && j <= 5 && leds !== 5'h01) || (j == 6 && leds !== 5'h02) ||
          (j < 4 && tick !== 1'b0) || (j == 4 && tick !== 1'b1))
        $display("FAIL switch_restart[%0d] leds=%h tick=%b required leds=%h tick=%b",
                 j, leds, tick, m_leds, exp_tick());
      else n_pass++;
    end
  endtask

  task automatic test_enable_manual();
    logic [N-1:0] exp_man;
    mode = 2'd0; en = 1'b1;
    do_reset();
    for (int c = 0; c < 13; c++) clk_cycle();
    en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      clk_cycle();
      n_total++;
      if (tick !== 1'b0 || leds !== m_leds || leds1 !== m_leds1)
        $display("FAIL enable_frozen[%0d] leds=%h tick=%b required %h/0", c, leds, tick, m_leds);
      else n_pass++;
    end
    en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      clk_cycle();
      n_total++;
      if (tick !== exp_tick() || leds !== m_leds)
        $display("FAIL enable_resume[%0d] leds=%h tick=%b required %h/%b",
                 c, leds, tick, m_leds, exp_tick());
      else n_pass++;
    end
    mode = 2'd3;
    for (int c = 0; c < 3; c++) clk_cycle();
    pat = 5'h15;
    clk_cycle();
    n_total++;
    if (leds !== 5'h15) $display("FAIL manual_0x15 leds=%h required 15", leds);
    else n_pass++;
    exp_man = 5'h15;
    for (int c = 0; c < 30; c++) begin
      pat = N'($urandom);
      en = ($urandom_range(0, 3) != 0);
      if (en) exp_man = pat;
      clk_cycle();
      n_total++;
      if (leds !== exp_man || leds1 !== m_leds1)
        $display("FAIL manual_rand[%0d] leds=%h required %h", c, leds, exp_man);
      else n_pass++;
    end
    en = 1'b1;
  endtask

  task automatic test_random();
    int bad_cyc;
    bad_cyc = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      en    = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      pat   = N'($urandom);
      clk_cycle();
      if (tick !== exp_tick() || leds !== m_leds || leds1 !== m_leds1) begin
        bad_cyc++;
        if (bad_cyc <= 5)
          $display("FAIL random[%0d] leds=%h tick=%b leds1=%b required %h/%b/%b",
                   c, leds, tick, leds1, m_leds, exp_tick(), m_leds1);
      end
    end
    rst_n = 1'b1;
    n_total++;
    if (bad_cyc != 0) $display("FAIL random_total mismatching_cycles=%0d required 0", bad_cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_scan();
    test_breathe();
    test_mode_switch();
    test_enable_manual();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
